// File: rtl/uart_frame_parser.sv
// Extracts 55 AA CMD LEN payload CHK frames from a UART byte stream and buffers the payload.
// Optional inter-byte timeout: define FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned TIMEOUT_CYC = 52080
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_vld,
  output logic          frm_vld,
  output logic [7:0]    frm_cmd,
  output logic [7:0]    frm_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_vld,
  output logic [1:0]    err_code
);

  if (MAX_LEN < 1 || MAX_LEN > 255 || AW > 8 || (1 << AW) < MAX_LEN || TIMEOUT_CYC < 2)
  begin : g_bad_params
    $error("uart_frame_parser: inconsistent MAX_LEN/AW/TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK
  } state_e;

  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);
  localparam int unsigned Depth   = 1 << AW;

  state_e      state_q;
  logic [7:0]  cmd_q;
  logic [7:0]  len_q;
  logic [7:0]  sum_q;
  logic [7:0]  cnt_q;
  logic        frm_vld_q;
  logic [7:0]  frm_cmd_q;
  logic [7:0]  frm_len_q;
  logic        err_vld_q;
  logic [1:0]  err_code_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  pbuf_q [Depth];
  logic        wr_en;
  logic        tmo_hit;

  assign wr_en = rx_vld && (state_q == S_DATA);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned     TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TmoLast = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_q;

  // An arriving byte always beats an expiry in the same cycle.
  assign tmo_hit = !rx_vld && (state_q != S_IDLE) && (tmo_q == TmoLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (rx_vld || state_q == S_IDLE || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: state and outputs use <= so every branch sees pre-edge values of sum_q/cnt_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      frm_vld_q  <= 1'b0;
      frm_cmd_q  <= '0;
      frm_len_q  <= '0;
      err_vld_q  <= 1'b0;
      err_code_q <= '0;
    end else begin
      frm_vld_q <= 1'b0;
      err_vld_q <= 1'b0;
      if (rx_vld) begin
        unique case (state_q)
          S_IDLE: begin
            if (rx_data == 8'h55) state_q <= S_HDR2;
          end
          S_HDR2: begin
            if (rx_data == 8'hAA)      state_q <= S_CMD;
            else if (rx_data != 8'h55) state_q <= S_IDLE;
          end
          S_CMD: begin
            cmd_q   <= rx_data;
            sum_q   <= rx_data;
            state_q <= S_LEN;
          end
          S_LEN: begin
            len_q <= rx_data;
            sum_q <= sum_q + rx_data;
            cnt_q <= '0;
            if (rx_data > MaxLenB) begin
              err_vld_q  <= 1'b1;
              err_code_q <= 2'd1;
              state_q    <= S_IDLE;
            end else if (rx_data == 8'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            sum_q <= sum_q + rx_data;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == len_q - 8'd1) state_q <= S_CHK;
          end
          S_CHK: begin
            if (rx_data == sum_q) begin
              frm_vld_q <= 1'b1;
              frm_cmd_q <= cmd_q;
              frm_len_q <= len_q;
            end else begin
              err_vld_q  <= 1'b1;
              err_code_q <= 2'd2;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (tmo_hit) begin
        err_vld_q  <= 1'b1;
        err_code_q <= 2'd3;
        state_q    <= S_IDLE;
      end
    end
  end

  // NOTE: the payload RAM has no reset so it maps onto plain RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) pbuf_q[cnt_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= pbuf_q[rd_addr];
  end

  assign frm_vld  = frm_vld_q;
  assign frm_cmd  = frm_cmd_q;
  assign frm_len  = frm_len_q;
  assign err_vld  = err_vld_q;
  assign err_code = err_code_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus randomized frames
// checked against expectations derived from how each frame was constructed.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int AW      = 4;
  localparam int TMO     = 100;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] len;
  } frm_ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_vld = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          frm_vld;
  logic [7:0]    frm_cmd;
  logic [7:0]    frm_len;
  logic [7:0]    rd_data;
  logic          err_vld;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;
  logic [7:0] last_cmd = '0;
  logic [7:0] last_len = '0;

  frm_ev_t    frm_q[$];
  logic [1:0] err_q[$];

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN    (MAX_LEN),
    .AW         (AW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .frm_vld (frm_vld),
    .frm_cmd (frm_cmd),
    .frm_len (frm_len),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .err_vld (err_vld),
    .err_code(err_code)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (frm_vld) frm_q.push_back('{cmd: frm_cmd, len: frm_len});
      if (err_vld) err_q.push_back(err_code);
      if (frm_vld && err_vld) both_hi++;
    end
  end

  // Reference: a frame is the header, CMD, LEN, payload and the mod-256 sum of CMD+LEN+payload.
  function automatic bq_t make_frame(input logic [7:0] cmd, input bq_t pay, input logic [7:0] chk_xor);
    bq_t q;
    int  sum;
    sum = int'(cmd) + pay.size();
    foreach (pay[i]) sum += int'(pay[i]);
    q = {8'h55, 8'hAA, cmd, 8'(pay.size())};
    foreach (pay[i]) q.push_back(pay[i]);
    q.push_back(8'(sum % 256) ^ chk_xor);
    return q;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bq_t bytes, input int max_gap);
    foreach (bytes[i]) begin
      rx_data = bytes[i];
      rx_vld  = 1'b1;
      @(posedge clk);
      #1;
      rx_vld = 1'b0;
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if ({frm_vld, err_vld, frm_cmd, frm_len, rd_data, err_code} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {frm_vld, err_vld, frm_cmd, frm_len, rd_data, err_code});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    bq_t pay = {8'h01, 8'h02, 8'h03};
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19}, 0);
    idle(2);
    checks++;
    if (frm_q.size() !== 1 || err_q.size() !== 0) begin
      errors++;
      $display("FAIL good_pulses: got frm=%0d err=%0d required frm=1 err=0", frm_q.size(), err_q.size());
    end else begin
      checks++;
      if (frm_q[0].cmd !== 8'h10 || frm_q[0].len !== 8'd3) begin
        errors++;
        $display("FAIL good_cmd_len: got %h/%0d required 10/3", frm_q[0].cmd, frm_q[0].len);
      end
    end
    last_cmd = 8'h10;
    last_len = 8'd3;
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'(i);
      idle(1);
      checks++;
      if (rd_data !== pay[i]) begin
        errors++;
        $display("FAIL good_payload[%0d]: got %h required %h", i, rd_data, pay[i]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18}, 1);
    idle(2);
    checks++;
    if (frm_q.size() !== 0 || err_q.size() !== 1 || (err_q.size() == 1 && err_q[0] !== 2'd2)) begin
      errors++;
      $display("FAIL bad_chk: got frm=%0d err=%0d required frm=0 err=1 code=2", frm_q.size(), err_q.size());
    end
    checks++;
    if (frm_cmd !== last_cmd || frm_len !== last_len || err_code !== 2'd2) begin
      errors++;
      $display("FAIL bad_chk_hold: got %h/%0d/%0d required %h/%0d/2",
               frm_cmd, frm_len, err_code, last_cmd, last_len);
    end
  endtask

  task automatic test_len_overflow();
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'hAA, 8'h01, 8'h11}, 0);
    idle(2);
    checks++;
    if (err_q.size() !== 1 || frm_q.size() !== 0 || (err_q.size() == 1 && err_q[0] !== 2'd1)) begin
      errors++;
      $display("FAIL len_overflow: got frm=%0d err=%0d required frm=0 err=1 code=1", frm_q.size(), err_q.size());
    end
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'hAA, 8'h01, 8'h00, 8'h01}, 0);
    idle(2);
    checks++;
    if (frm_q.size() !== 1 || err_q.size() !== 0 || (frm_q.size() == 1 && frm_q[0].len !== 8'd0)) begin
      errors++;
      $display("FAIL zero_len: got frm=%0d err=%0d required frm=1 len=0", frm_q.size(), err_q.size());
    end
    last_cmd = 8'h01;
    last_len = 8'd0;
  endtask

  task automatic test_back_to_back();
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'h55, 8'hAA, 8'h20, 8'h01, 8'hF0, 8'h11,
          8'h55, 8'hAA, 8'h21, 8'h00, 8'h21}, 0);
    idle(2);
    checks++;
    if (frm_q.size() !== 2 || err_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_pulses: got frm=%0d err=%0d required frm=2 err=0", frm_q.size(), err_q.size());
    end else begin
      checks++;
      if (frm_q[0].cmd !== 8'h20 || frm_q[0].len !== 8'd1 ||
          frm_q[1].cmd !== 8'h21 || frm_q[1].len !== 8'd0) begin
        errors++;
        $display("FAIL b2b_fields: got %h/%0d %h/%0d required 20/1 21/0",
                 frm_q[0].cmd, frm_q[0].len, frm_q[1].cmd, frm_q[1].len);
      end
    end
    last_cmd = 8'h21;
    last_len = 8'd0;
    rd_addr = '0;
    idle(1);
    checks++;
    if (rd_data !== 8'hF0) begin
      errors++;
      $display("FAIL b2b_buf0: got %h required f0", rd_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'hAA, 8'h10, 8'h03, 8'h01}, 0);
    rst = 1'b1;
    idle(2);
    checks++;
    if ({frm_vld, err_vld, frm_cmd, frm_len, rd_data, err_code} !== 28'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h required 0",
               {frm_vld, err_vld, frm_cmd, frm_len, rd_data, err_code});
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (frm_q.size() !== 0 || err_q.size() !== 0) begin
      errors++;
      $display("FAIL midrst_pulses: got frm=%0d err=%0d required 0/0", frm_q.size(), err_q.size());
    end
    send(make_frame(8'h33, {8'h0A, 8'hFF}, 8'h00), 0);
    idle(2);
    checks++;
    if (frm_q.size() !== 1 || err_q.size() !== 0 ||
        (frm_q.size() == 1 && (frm_q[0].cmd !== 8'h33 || frm_q[0].len !== 8'd2))) begin
      errors++;
      $display("FAIL midrst_recover: got frm=%0d err=%0d required one frame 33/2", frm_q.size(), err_q.size());
    end
    last_cmd = 8'h33;
    last_len = 8'd2;
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int         kind;
      logic [7:0] cmd;
      bq_t        pay;
      bq_t        bytes;
      kind = int'($urandom_range(0, 3));
      cmd  = 8'($urandom_range(0, 255));
      pay.delete();
      bytes.delete();
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] n;
        n = 8'($urandom_range(0, 255));
        if (n == 8'h55) n = 8'h00;
        bytes.push_back(n);
      end
      if (kind == 3) begin
        bytes = {bytes, 8'h55, 8'hAA, cmd, 8'($urandom_range(MAX_LEN + 1, 255))};
      end else begin
        repeat ($urandom_range(0, MAX_LEN)) pay.push_back(8'($urandom_range(0, 255)));
        bytes = {bytes, make_frame(cmd, pay, (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00)};
      end
      frm_q.delete();
      err_q.delete();
      send(bytes, (f % 2 == 0) ? 0 : 3);
      idle(2);
      checks++;
      if (kind < 2) begin
        if (frm_q.size() !== 1 || err_q.size() !== 0 ||
            (frm_q.size() == 1 && (frm_q[0].cmd !== cmd || frm_q[0].len !== 8'(pay.size())))) begin
          errors++;
          $display("FAIL rand_good[%0d]: got frm=%0d err=%0d required frm=1 cmd=%h len=%0d",
                   f, frm_q.size(), err_q.size(), cmd, pay.size());
        end
        last_cmd = cmd;
        last_len = 8'(pay.size());
        foreach (pay[i]) begin
          rd_addr = AW'(i);
          idle(1);
          checks++;
          if (rd_data !== pay[i]) begin
            errors++;
            $display("FAIL rand_payload[%0d][%0d]: got %h required %h", f, i, rd_data, pay[i]);
          end
        end
      end else begin
        if (frm_q.size() !== 0 || err_q.size() !== 1 ||
            (err_q.size() == 1 && err_q[0] !== ((kind == 2) ? 2'd2 : 2'd1)) ||
            frm_cmd !== last_cmd || frm_len !== last_len) begin
          errors++;
          $display("FAIL rand_err[%0d]: got frm=%0d err=%0d cmd=%h len=%0d required err code %0d, held %h/%0d",
                   f, frm_q.size(), err_q.size(), frm_cmd, frm_len, (kind == 2) ? 2 : 1, last_cmd, last_len);
        end
      end
    end
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    frm_q.delete();
    err_q.delete();
    seen = -1;
    send({8'h55, 8'hAA, 8'h10}, 0);
    for (int k = 1; k <= 3 * TMO; k++) begin
      idle(1);
      if (err_vld) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen !== TMO || err_code !== 2'd3) begin
      errors++;
      $display("FAIL timeout: got delay=%0d code=%0d required delay=%0d code=3", seen, err_code, TMO);
    end
    idle(2);
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'hAA, 8'h10}, 0);
    idle(TMO - 2);
    send({8'h00, 8'h10}, 0);
    idle(2);
    checks++;
    if (err_q.size() !== 0 || frm_q.size() !== 1) begin
      errors++;
      $display("FAIL timeout_edge: got frm=%0d err=%0d required frm=1 err=0", frm_q.size(), err_q.size());
    end
  endtask
`else
  task automatic test_timeout();
    frm_q.delete();
    err_q.delete();
    send({8'h55, 8'hAA, 8'h10}, 0);
    idle(3 * TMO);
    send({8'h00, 8'h10}, 0);
    idle(2);
    checks++;
    if (err_q.size() !== 0 || frm_q.size() !== 1) begin
      errors++;
      $display("FAIL no_timeout: got frm=%0d err=%0d required frm=1 err=0", frm_q.size(), err_q.size());
    end
  endtask
`endif

  task automatic test_exclusive();
    checks++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles required 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_timeout();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
